// File: rtl/mips32_mc_pkg.sv
// Shared types and encodings for the multi-cycle MIPS32 control FSM and its decoder.
package mips32_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_WB_ALU   = 4'd4,
    S_MEM_ADDR = 4'd5,
    S_MEM_RD   = 4'd6,
    S_MEM_WR   = 4'd7,
    S_WB_MEM   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  typedef enum logic [2:0] {
    CLS_R, CLS_I, CLS_LW, CLS_SW, CLS_BEQ, CLS_BNE, CLS_J, CLS_INV
  } instr_class_t;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_J     = 6'h02;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_BNE   = 6'h05;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_SLTI  = 6'h0A;
  localparam logic [5:0] OPC_ANDI  = 6'h0C;
  localparam logic [5:0] OPC_ORI   = 6'h0D;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;

  localparam logic [5:0] FUNC_ADD = 6'h20;
  localparam logic [5:0] FUNC_SUB = 6'h22;
  localparam logic [5:0] FUNC_AND = 6'h24;
  localparam logic [5:0] FUNC_OR  = 6'h25;
  localparam logic [5:0] FUNC_SLT = 6'h2A;

  localparam logic [2:0] ALU_AND = 3'd0;
  localparam logic [2:0] ALU_OR  = 3'd1;
  localparam logic [2:0] ALU_ADD = 3'd2;
  localparam logic [2:0] ALU_SUB = 3'd6;
  localparam logic [2:0] ALU_SLT = 3'd7;

  localparam logic [1:0] PC_SRC_SEQ    = 2'd0;
  localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

  localparam logic [1:0] SRC_B_RT      = 2'd0;
  localparam logic [1:0] SRC_B_FOUR    = 2'd1;
  localparam logic [1:0] SRC_B_IMM     = 2'd2;
  localparam logic [1:0] SRC_B_IMM_SH2 = 2'd3;

endpackage

// File: rtl/mips32_mc_decode.sv
// Combinational instruction classifier: opc/func -> class, ALU operation, extension mode, validity.
module mips32_mc_decode
  import mips32_mc_pkg::*;
#(
  parameter int ALU_FUNC_W = 3
) (
  input  logic [5:0]            opc,
  input  logic [5:0]            func,
  output instr_class_t          cls,
  output logic [ALU_FUNC_W-1:0] alu_func,
  output logic                  bit_xtend,
  output logic                  valid
);

  logic [2:0] alu_code;

  always_comb begin
    cls       = CLS_INV;
    alu_code  = ALU_ADD;
    bit_xtend = 1'b0;
    case (opc)
      OPC_RTYPE: begin
        case (func)
          FUNC_ADD: begin cls = CLS_R; alu_code = ALU_ADD; end
          FUNC_SUB: begin cls = CLS_R; alu_code = ALU_SUB; end
          FUNC_AND: begin cls = CLS_R; alu_code = ALU_AND; end
          FUNC_OR:  begin cls = CLS_R; alu_code = ALU_OR;  end
          FUNC_SLT: begin cls = CLS_R; alu_code = ALU_SLT; end
          default:  cls = CLS_INV;
        endcase
      end
      OPC_ADDI: begin cls = CLS_I; alu_code = ALU_ADD; end
      OPC_SLTI: begin cls = CLS_I; alu_code = ALU_SLT; end
      OPC_ANDI: begin cls = CLS_I; alu_code = ALU_AND; bit_xtend = 1'b1; end
      OPC_ORI:  begin cls = CLS_I; alu_code = ALU_OR;  bit_xtend = 1'b1; end
      OPC_LW:   cls = CLS_LW;
      OPC_SW:   cls = CLS_SW;
      OPC_BEQ:  begin cls = CLS_BEQ; alu_code = ALU_SUB; end
      OPC_BNE:  begin cls = CLS_BNE; alu_code = ALU_SUB; end
      OPC_J:    cls = CLS_J;
      default:  cls = CLS_INV;
    endcase
  end

  assign alu_func = ALU_FUNC_W'(alu_code);
  assign valid    = (cls != CLS_INV);

endmodule

// File: rtl/mips32_multicycle_ctrl.sv
// Multi-cycle MIPS32 control FSM with memory-wait timeout and invalid-instruction trap.
// Optional performance counters are enabled by defining MIPS32_MC_PERF_EN.
module mips32_multicycle_ctrl
  import mips32_mc_pkg::*;
#(
  parameter int ALU_FUNC_W  = 3,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [5:0]            opc,
  input  logic [5:0]            func,
  input  logic                  zero,
  input  logic                  mem_ready,
  output logic                  pc_write,
  output logic [1:0]            pc_src,
  output logic                  ir_write,
  output logic                  iord,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [ALU_FUNC_W-1:0] alu_func,
  output logic                  bit_xtend,
  output logic                  rf_write_enable,
  output logic                  rf_write_addr_sel,
  output logic [1:0]            rf_write_data_sel,
  output logic                  inv_opcode,
  output logic                  mem_timeout,
  output logic [3:0]            state_o
`ifdef MIPS32_MC_PERF_EN
  ,
  output logic [CNT_W-1:0]      instr_retired,
  output logic [CNT_W-1:0]      stall_cycles
`endif
);

  localparam bit TIMEOUT_EN = (MEM_TIMEOUT != 0);
  localparam int WAIT_W     = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT - 1);

  state_t                  state;
  logic [WAIT_W-1:0]       wait_cnt;
  logic                    inv_q;
  logic                    tmo_q;
  instr_class_t            dec_cls;
  logic [ALU_FUNC_W-1:0]   dec_alu;
  logic                    dec_xtend;
  logic                    dec_valid;
  logic                    waiting;
  logic                    timed_out;

  mips32_mc_decode #(.ALU_FUNC_W(ALU_FUNC_W)) u_decode (
    .opc       (opc),
    .func      (func),
    .cls       (dec_cls),
    .alu_func  (dec_alu),
    .bit_xtend (dec_xtend),
    .valid     (dec_valid)
  );

  assign waiting   = ((state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR)) && !mem_ready;
  // The wait that would push the count to the limit traps; a ready in that cycle takes priority.
  assign timed_out = TIMEOUT_EN && waiting && (wait_cnt == WAIT_LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
      inv_q    <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      wait_cnt <= (TIMEOUT_EN && waiting) ? wait_cnt + 1'b1 : '0;
      if (timed_out) begin
        state <= S_TRAP;
        tmo_q <= 1'b1;
      end else begin
        case (state)
          S_FETCH:  if (mem_ready) state <= S_DECODE;
          S_DECODE: begin
            if (!dec_valid) begin
              state <= S_TRAP;
              inv_q <= 1'b1;
            end else begin
              case (dec_cls)
                CLS_R:            state <= S_EXEC_R;
                CLS_I:            state <= S_EXEC_I;
                CLS_LW, CLS_SW:   state <= S_MEM_ADDR;
                CLS_BEQ, CLS_BNE: state <= S_BRANCH;
                CLS_J:            state <= S_JUMP;
                default: begin
                  state <= S_TRAP;
                  inv_q <= 1'b1;
                end
              endcase
            end
          end
          S_EXEC_R, S_EXEC_I: state <= S_WB_ALU;
          S_MEM_ADDR: state <= (dec_cls == CLS_SW) ? S_MEM_WR : S_MEM_RD;
          S_MEM_RD:   if (mem_ready) state <= S_WB_MEM;
          S_MEM_WR:   if (mem_ready) state <= S_FETCH;
          S_WB_ALU, S_WB_MEM, S_BRANCH, S_JUMP: state <= S_FETCH;
          default:    state <= S_TRAP;
        endcase
      end
    end
  end

  // Strobes are forced low for as long as reset is held, not just at the edge.
  always_comb begin
    pc_write          = 1'b0;
    pc_src            = PC_SRC_SEQ;
    ir_write          = 1'b0;
    iord              = 1'b0;
    mem_read          = 1'b0;
    mem_write         = 1'b0;
    alu_src_a         = 1'b0;
    alu_src_b         = SRC_B_RT;
    alu_func          = '0;
    bit_xtend         = 1'b0;
    rf_write_enable   = 1'b0;
    rf_write_addr_sel = 1'b0;
    rf_write_data_sel = 2'd0;
    if (rst_n) begin
      case (state)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = SRC_B_FOUR;
          alu_func  = ALU_FUNC_W'(ALU_ADD);
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE: begin
          alu_src_b = SRC_B_IMM_SH2;
          alu_func  = ALU_FUNC_W'(ALU_ADD);
        end
        S_EXEC_R: begin
          alu_src_a = 1'b1;
          alu_func  = dec_alu;
        end
        S_EXEC_I: begin
          alu_src_a = 1'b1;
          alu_src_b = SRC_B_IMM;
          alu_func  = dec_alu;
          bit_xtend = dec_xtend;
        end
        S_WB_ALU: begin
          rf_write_enable   = 1'b1;
          rf_write_addr_sel = (opc == OPC_RTYPE);
        end
        S_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = SRC_B_IMM;
          alu_func  = ALU_FUNC_W'(ALU_ADD);
        end
        S_MEM_RD: begin
          mem_read = 1'b1;
          iord     = 1'b1;
        end
        S_MEM_WR: begin
          mem_write = 1'b1;
          iord      = 1'b1;
        end
        S_WB_MEM: begin
          rf_write_enable   = 1'b1;
          rf_write_data_sel = 2'd1;
        end
        S_BRANCH: begin
          alu_src_a = 1'b1;
          alu_func  = ALU_FUNC_W'(ALU_SUB);
          pc_src    = PC_SRC_BRANCH;
          pc_write  = ((dec_cls == CLS_BEQ) && zero) || ((dec_cls == CLS_BNE) && !zero);
        end
        S_JUMP: begin
          pc_write = 1'b1;
          pc_src   = PC_SRC_JUMP;
        end
        default: ;
      endcase
    end
  end

  assign inv_opcode  = inv_q;
  assign mem_timeout = tmo_q;
  assign state_o     = state;

`ifdef MIPS32_MC_PERF_EN
  logic retire;

  assign retire = (state == S_WB_ALU) || (state == S_WB_MEM) || (state == S_BRANCH) ||
                  (state == S_JUMP) || ((state == S_MEM_WR) && mem_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_retired <= '0;
      stall_cycles  <= '0;
    end else begin
      if (retire)  instr_retired <= instr_retired + 1'b1;
      if (waiting) stall_cycles  <= stall_cycles + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mips32_multicycle_ctrl.sv
// Scoreboard bench for mips32_multicycle_ctrl: an instruction-level model queues per-cycle expectations.
// Builds with or without MIPS32_MC_PERF_EN.
module tb_mips32_multicycle_ctrl;
  import mips32_mc_pkg::*;

  localparam int TIMEOUT = 16;

  localparam int K_R   = 0;
  localparam int K_I   = 1;
  localparam int K_LW  = 2;
  localparam int K_SW  = 3;
  localparam int K_BR  = 4;
  localparam int K_J   = 5;
  localparam int K_INV = 6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opc = '0;
  logic [5:0] func = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;

  logic       pc_write, ir_write, iord, mem_read, mem_write, alu_src_a, bit_xtend;
  logic [1:0] pc_src, alu_src_b, rf_write_data_sel;
  logic [2:0] alu_func;
  logic       rf_write_enable, rf_write_addr_sel, inv_opcode, mem_timeout;
  logic [3:0] state_o;
`ifdef MIPS32_MC_PERF_EN
  logic [31:0] instr_retired, stall_cycles;
  bit          perf_zero_pending = 1'b0;
`endif

  typedef struct packed {
    logic [3:0] state;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       ir_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_func;
    logic       bit_xtend;
    logic       rf_we;
    logic       addr_sel;
    logic [1:0] data_sel;
    logic       inv;
    logic       tmo;
  } obs_t;

  obs_t exp_q[$];
  obs_t mon_exp, mon_act;
  int   vectors = 0;
  int   miscompares = 0;
  int   model_retired = 0;
  int   model_stalls = 0;
  logic inv_m = 1'b0;
  logic tmo_m = 1'b0;

  mips32_multicycle_ctrl #(.ALU_FUNC_W(3), .MEM_TIMEOUT(TIMEOUT), .CNT_W(32)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .opc               (opc),
    .func              (func),
    .zero              (zero),
    .mem_ready         (mem_ready),
    .pc_write          (pc_write),
    .pc_src            (pc_src),
    .ir_write          (ir_write),
    .iord              (iord),
    .mem_read          (mem_read),
    .mem_write         (mem_write),
    .alu_src_a         (alu_src_a),
    .alu_src_b         (alu_src_b),
    .alu_func          (alu_func),
    .bit_xtend         (bit_xtend),
    .rf_write_enable   (rf_write_enable),
    .rf_write_addr_sel (rf_write_addr_sel),
    .rf_write_data_sel (rf_write_data_sel),
    .inv_opcode        (inv_opcode),
    .mem_timeout       (mem_timeout),
    .state_o           (state_o)
`ifdef MIPS32_MC_PERF_EN
    ,
    .instr_retired     (instr_retired),
    .stall_cycles      (stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  function automatic obs_t observed();
    obs_t a;
    a.state     = state_o;
    a.pc_write  = pc_write;
    a.pc_src    = pc_src;
    a.ir_write  = ir_write;
    a.iord      = iord;
    a.mem_read  = mem_read;
    a.mem_write = mem_write;
    a.alu_src_a = alu_src_a;
    a.alu_src_b = alu_src_b;
    a.alu_func  = alu_func;
    a.bit_xtend = bit_xtend;
    a.rf_we     = rf_write_enable;
    a.addr_sel  = rf_write_addr_sel;
    a.data_sel  = rf_write_data_sel;
    a.inv       = inv_opcode;
    a.tmo       = mem_timeout;
    return a;
  endfunction

  // Monitor: every cycle that has a queued expectation is compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_exp = exp_q.pop_front();
      mon_act = observed();
      vectors++;
      if (mon_act !== mon_exp) begin
        miscompares++;
        $display("[TB] FAIL cycle_outputs t=%0t exp_state=%0d got=%h expected=%h",
                 $time, mon_exp.state, mon_act, mon_exp);
      end
    end
  end

`ifdef MIPS32_MC_PERF_EN
  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("[TB] FAIL %s got=%0d expected=%0d", name, act, want);
    end
  endtask

  task automatic check_perf();
    #3;
    check_output("instr_retired", instr_retired, 32'(model_retired));
    check_output("stall_cycles", stall_cycles, 32'(model_stalls));
  endtask
`endif

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic obs_t idle(input state_t s);
    obs_t e;
    e       = '0;
    e.state = s;
    e.inv   = inv_m;
    e.tmo   = tmo_m;
    return e;
  endfunction

  function automatic int classify(input logic [5:0] o, input logic [5:0] f);
    case (o)
      6'h00:                      return (f inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A}) ? K_R : K_INV;
      6'h08, 6'h0A, 6'h0C, 6'h0D: return K_I;
      6'h23:                      return K_LW;
      6'h2B:                      return K_SW;
      6'h04, 6'h05:               return K_BR;
      6'h02:                      return K_J;
      default:                    return K_INV;
    endcase
  endfunction

  function automatic logic [2:0] r_alu(input logic [5:0] f);
    case (f)
      6'h22:   return ALU_SUB;
      6'h24:   return ALU_AND;
      6'h25:   return ALU_OR;
      6'h2A:   return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

  function automatic logic [2:0] i_alu(input logic [5:0] o);
    case (o)
      6'h0A:   return ALU_SLT;
      6'h0C:   return ALU_AND;
      6'h0D:   return ALU_OR;
      default: return ALU_ADD;
    endcase
  endfunction

  task automatic apply_stimulus(input logic [5:0] o, input logic [5:0] f, input logic rdy,
                                input logic z, input obs_t e);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    opc       = o;
    func      = f;
    mem_ready = rdy;
    zero      = z;
    exp_q.push_back(e);
`ifdef MIPS32_MC_PERF_EN
    if (perf_zero_pending) begin
      perf_zero_pending = 1'b0;
      #3;
      check_output("instr_retired_after_reset", instr_retired, 32'd0);
      check_output("stall_cycles_after_reset", stall_cycles, 32'd0);
    end
`endif
  endtask

  task automatic do_reset(input int n);
    inv_m         = 1'b0;
    tmo_m         = 1'b0;
    model_retired = 0;
    model_stalls  = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      rst_n     = 1'b0;
      mem_ready = rnd();
      zero      = rnd();
      exp_q.push_back('0);
    end
`ifdef MIPS32_MC_PERF_EN
    perf_zero_pending = 1'b1;
`endif
  endtask

  // A memory phase: `waits` cycles without ready, then one ready cycle unless it times out or is aborted.
  task automatic mem_phase(input state_t s, input int waits, input bit no_ready,
                           input logic [5:0] o, input logic [5:0] f, output bit to);
    obs_t e;
    to = 1'b0;
    e  = idle(s);
    if (s == S_FETCH) begin
      e.mem_read  = 1'b1;
      e.alu_src_b = 2'd1;
      e.alu_func  = ALU_ADD;
    end else if (s == S_MEM_RD) begin
      e.mem_read = 1'b1;
      e.iord     = 1'b1;
    end else begin
      e.mem_write = 1'b1;
      e.iord      = 1'b1;
    end
    for (int w = 0; w < waits; w++) begin
      apply_stimulus(o, f, 1'b0, rnd(), e);
      model_stalls++;
      if (w + 1 == TIMEOUT) begin
        tmo_m = 1'b1;
        to    = 1'b1;
        return;
      end
    end
    if (no_ready) return;
    if (s == S_FETCH) begin
      e.ir_write = 1'b1;
      e.pc_write = 1'b1;
    end
    apply_stimulus(o, f, 1'b1, rnd(), e);
  endtask

  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                           input int fw, input int mw, input bit abort_mem);
    obs_t e;
    bit   to;
    int   k;
    k = classify(o, f);
    mem_phase(S_FETCH, fw, 1'b0, o, f, to);
    if (to) return;
    e = idle(S_DECODE);
    e.alu_src_b = 2'd3;
    e.alu_func  = ALU_ADD;
    apply_stimulus(o, f, rnd(), rnd(), e);
    case (k)
      K_R, K_I: begin
        e = idle((k == K_R) ? S_EXEC_R : S_EXEC_I);
        e.alu_src_a = 1'b1;
        e.alu_src_b = (k == K_R) ? 2'd0 : 2'd2;
        e.alu_func  = (k == K_R) ? r_alu(f) : i_alu(o);
        e.bit_xtend = (o == 6'h0C) || (o == 6'h0D);
        apply_stimulus(o, f, rnd(), rnd(), e);
        e = idle(S_WB_ALU);
        e.rf_we    = 1'b1;
        e.addr_sel = (k == K_R);
        apply_stimulus(o, f, rnd(), rnd(), e);
      end
      K_LW, K_SW: begin
        e = idle(S_MEM_ADDR);
        e.alu_src_a = 1'b1;
        e.alu_src_b = 2'd2;
        e.alu_func  = ALU_ADD;
        apply_stimulus(o, f, rnd(), rnd(), e);
        mem_phase((k == K_LW) ? S_MEM_RD : S_MEM_WR, mw, abort_mem, o, f, to);
        if (to || abort_mem) return;
        if (k == K_LW) begin
          e = idle(S_WB_MEM);
          e.rf_we    = 1'b1;
          e.data_sel = 2'd1;
          apply_stimulus(o, f, rnd(), rnd(), e);
        end
      end
      K_BR: begin
        e = idle(S_BRANCH);
        e.alu_src_a = 1'b1;
        e.alu_func  = ALU_SUB;
        e.pc_src    = 2'd1;
        e.pc_write  = (o == 6'h04) ? z : !z;
        apply_stimulus(o, f, rnd(), z, e);
      end
      K_J: begin
        e = idle(S_JUMP);
        e.pc_write = 1'b1;
        e.pc_src   = 2'd2;
        apply_stimulus(o, f, rnd(), rnd(), e);
      end
      default: begin
        inv_m = 1'b1;
        return;
      end
    endcase
    model_retired++;
  endtask

  task automatic hold_trap(input int n);
    for (int i = 0; i < n; i++)
      apply_stimulus(6'($urandom), 6'($urandom), rnd(), rnd(), idle(S_TRAP));
  endtask

  logic [5:0] valid_opc [10] = '{6'h00, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02};
  logic [5:0] valid_fn  [5]  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};

  initial begin
    logic [5:0] o, f;
    do_reset(2);

    run_instr(6'h00, 6'h20, 1'b0, 0, 0, 1'b0);
    run_instr(6'h23, 6'($urandom), 1'b0, 0, 3, 1'b0);
    run_instr(6'h04, 6'($urandom), 1'b1, 0, 0, 1'b0);
    run_instr(6'h05, 6'($urandom), 1'b1, 0, 0, 1'b0);
    run_instr(6'h05, 6'($urandom), 1'b0, 0, 0, 1'b0);
    run_instr(6'h04, 6'($urandom), 1'b0, 0, 0, 1'b0);
    run_instr(6'h08, 6'($urandom), 1'b0, TIMEOUT - 1, 0, 1'b0);
    run_instr(6'h2B, 6'($urandom), 1'b0, 0, 2, 1'b0);
    run_instr(6'h02, 6'($urandom), 1'b0, 1, 0, 1'b0);
    run_instr(6'h0C, 6'($urandom), 1'b0, 0, 0, 1'b0);
    run_instr(6'h23, 6'($urandom), 1'b0, 0, TIMEOUT - 1, 1'b0);

    for (int i = 0; i < 40; i++) begin
      o = valid_opc[$urandom_range(0, 9)];
      f = (o == 6'h00) ? valid_fn[$urandom_range(0, 4)] : 6'($urandom);
      run_instr(o, f, rnd(), int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 1'b0);
    end

    run_instr(6'h2B, 6'($urandom), 1'b0, 0, 2, 1'b1);
    do_reset(1);
    run_instr(6'h00, 6'h25, 1'b0, 0, 0, 1'b0);

    run_instr(6'h3F, 6'($urandom), 1'b0, 0, 0, 1'b0);
    hold_trap(6);
`ifdef MIPS32_MC_PERF_EN
    check_perf();
`endif
    do_reset(1);

    run_instr(6'h0D, 6'($urandom), 1'b0, 0, 0, 1'b0);
    run_instr(6'h00, 6'h00, 1'b0, 0, 0, 1'b0);
    hold_trap(6);
`ifdef MIPS32_MC_PERF_EN
    check_perf();
`endif
    do_reset(2);

    run_instr(6'h00, 6'h22, 1'b0, TIMEOUT, 0, 1'b0);
    hold_trap(5);
`ifdef MIPS32_MC_PERF_EN
    check_perf();
`endif
    do_reset(1);

    run_instr(6'h23, 6'($urandom), 1'b0, 1, TIMEOUT + 4, 1'b0);
    hold_trap(5);
`ifdef MIPS32_MC_PERF_EN
    check_perf();
`endif
    do_reset(1);

    run_instr(6'h00, 6'h2A, 1'b0, 0, 0, 1'b0);
    run_instr(6'h0A, 6'($urandom), 1'b0, 0, 0, 1'b0);

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
